// File: rtl/mul_fdc.sv
// mul_fdc: complex NCO mixer (multiply by exp(-j*theta)) followed by a
// 4-sample boxcar decimator. One sample per clk_fs; outputs at fs/4.
//
// Output handshake: out_valid is a one-cycle strobe with no ready. It is high
// in exactly the cycle where Iout/Qout hold a newly computed value. Between
// strobes the outputs keep their last value. A consumer must take the data in
// the strobe cycle, because the block never stalls.
module mul_fdc #(
  parameter int BW  = 12,
  parameter int ABW = 10
) (
  input  logic                  clk_fs,
  input  logic                  rstb,
  input  logic signed [BW-1:0]  Iin,
  input  logic signed [BW-1:0]  Qin,
  input  logic        [ABW-1:0] Wif,
  output logic signed [BW-1:0]  Iout,
  output logic signed [BW-1:0]  Qout,
  output logic                  out_valid
);

  localparam int QN = 2**(ABW-2);   // quarter-wave table entries
  localparam int PW = 2*BW;         // product width
  localparam int SW = 2*BW+1;       // mixer sum width
  localparam int AW = BW+2;         // decimator accumulator width

  localparam logic signed [BW-1:0] AMAX = BW'(2**(BW-1)-1);
  localparam logic signed [BW-1:0] AMIN = BW'(-(2**(BW-1)));
  localparam logic signed [SW-1:0] SMAX = SW'(2**(BW-1)-1);
  localparam logic signed [SW-1:0] SMIN = SW'(-(2**(BW-1)));

  // Quarter-wave sine entry, rounded to nearest. Only evaluated at elaboration.
  function automatic logic signed [BW-1:0] rom_value(input int k);
    real a;
    a = real'(2**(BW-1)-1) * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(4*QN));
    return BW'($rtoi(a + 0.5));
  endfunction

  // Scale a mixer sum back to BW bits: floor shift, then clamp.
  function automatic logic signed [BW-1:0] scale_sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] s;
    s = v >>> (BW-1);
    if (s > SMAX)      return AMAX;
    else if (s < SMIN) return AMIN;
    else               return s[BW-1:0];
  endfunction

  // Constant quarter-wave table; the peak at index QN is supplied by the folding logic.
  logic signed [BW-1:0] rom [QN];
  for (genvar k = 0; k < QN; k++) begin : g_rom
    localparam logic signed [BW-1:0] V = rom_value(k);
    assign rom[k] = V;
  end

  // ---------------- Stage 0: capture and NCO ----------------
  logic [ABW-1:0]       phase;
  logic [ABW-1:0]       s0_p;
  logic signed [BW-1:0] s0_i, s0_q;
  logic                 s0_v;

  // Capture the sample together with the phase it is mixed with, then advance the NCO.
  always_ff @(posedge clk_fs or negedge rstb) begin
    if (!rstb) begin
      phase <= '0;
      s0_p  <= '0;
      s0_i  <= '0;
      s0_q  <= '0;
      s0_v  <= 1'b0;
    end else begin
      s0_p  <= phase;
      s0_i  <= Iin;
      s0_q  <= Qin;
      phase <= phase + Wif;
      s0_v  <= 1'b1;
    end
  end

  // ---------------- Stage 1: cos/sin lookup ----------------
  logic [1:0]           quad;
  logic [ABW-3:0]       idx;
  logic [ABW-3:0]       idx_c;
  logic signed [BW-1:0] mag_a, mag_b, cos_w, sin_w;

  // Fold the phase into one quadrant: mag_a = T(idx), mag_b = T(QN-idx), T(QN) = peak.
  always_comb begin
    quad  = s0_p[ABW-1:ABW-2];
    idx   = s0_p[ABW-3:0];
    idx_c = (ABW-2)'(0) - idx;
    mag_a = rom[idx];
    mag_b = (idx == '0) ? AMAX : rom[idx_c];
    sin_w = mag_a;
    cos_w = mag_b;
    case (quad)
      2'd0: begin sin_w = mag_a;  cos_w = mag_b;  end
      2'd1: begin sin_w = mag_b;  cos_w = -mag_a; end
      2'd2: begin sin_w = -mag_a; cos_w = -mag_b; end
      default: begin sin_w = -mag_b; cos_w = mag_a; end
    endcase
  end

  logic signed [BW-1:0] s1_i, s1_q, s1_cos, s1_sin;
  logic                 s1_v;

  // Register the looked-up oscillator values alongside the delayed sample.
  always_ff @(posedge clk_fs or negedge rstb) begin
    if (!rstb) begin
      s1_i   <= '0;
      s1_q   <= '0;
      s1_cos <= '0;
      s1_sin <= '0;
      s1_v   <= 1'b0;
    end else begin
      s1_i   <= s0_i;
      s1_q   <= s0_q;
      s1_cos <= cos_w;
      s1_sin <= sin_w;
      s1_v   <= s0_v;
    end
  end

  // ---------------- Stage 2: products ----------------
  logic signed [PW-1:0] p_ic, p_qs, p_qc, p_is;
  logic                 s2_v;

  // Four full-precision products of the complex multiply.
  always_ff @(posedge clk_fs or negedge rstb) begin
    if (!rstb) begin
      p_ic <= '0;
      p_qs <= '0;
      p_qc <= '0;
      p_is <= '0;
      s2_v <= 1'b0;
    end else begin
      p_ic <= s1_i * s1_cos;
      p_qs <= s1_q * s1_sin;
      p_qc <= s1_q * s1_cos;
      p_is <= s1_i * s1_sin;
      s2_v <= s1_v;
    end
  end

  // ---------------- Stage 3: sum, scale, saturate ----------------
  logic signed [SW-1:0] sum_i, sum_q;
  assign sum_i = SW'(p_ic) + SW'(p_qs);
  assign sum_q = SW'(p_qc) - SW'(p_is);

  logic signed [BW-1:0] m_i, m_q;
  logic                 m_v;

  // Mixer output register; m_v marks samples that came from real input.
  always_ff @(posedge clk_fs or negedge rstb) begin
    if (!rstb) begin
      m_i <= '0;
      m_q <= '0;
      m_v <= 1'b0;
    end else begin
      m_i <= scale_sat(sum_i);
      m_q <= scale_sat(sum_q);
      m_v <= s2_v;
    end
  end

  // ---------------- Decimator ----------------
  logic [1:0]           cnt;
  logic signed [AW-1:0] acc_i, acc_q, tot_i, tot_q;

  assign tot_i = acc_i + AW'(m_i);
  assign tot_q = acc_q + AW'(m_q);

  // Sum four mixer samples; on the fourth, publish sum/4 (floor) and restart.
  always_ff @(posedge clk_fs or negedge rstb) begin
    if (!rstb) begin
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      Iout      <= '0;
      Qout      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (m_v) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          Iout      <= tot_i[AW-1:2];
          Qout      <= tot_q[AW-1:2];
          out_valid <= 1'b1;
          acc_i     <= '0;
          acc_q     <= '0;
        end else begin
          acc_i <= tot_i;
          acc_q <= tot_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_fdc.sv
// tb_mul_fdc: directed vectors for the NCO mixer / 4:1 decimator.
// Timing reference: rstb is released just after a falling edge with sample 0
// on the inputs; sample n is captured by rising edge n+1. With four register
// stages plus the decimator, the first out_valid is seen after rising edge 8,
// i.e. 7 edges after the edge that captured sample 0.
module tb_mul_fdc;
  localparam int BW  = 12;
  localparam int ABW = 10;
  localparam real PI = 3.14159265358979323846;

  logic                  clk_fs = 1'b0;
  logic                  rstb   = 1'b1;
  logic signed [BW-1:0]  Iin    = '0;
  logic signed [BW-1:0]  Qin    = '0;
  logic        [ABW-1:0] Wif    = '0;
  logic signed [BW-1:0]  Iout;
  logic signed [BW-1:0]  Qout;
  logic                  out_valid;

  int n_checks = 0;
  int n_err    = 0;

  // Scoreboard: expected {Iout, Qout} per output window, in order.
  logic [2*BW-1:0] exp_q[$];

  typedef struct {
    string              name;
    logic [ABW-1:0]     wif;
    logic [3:0][BW-1:0] ip;
    logic [3:0][BW-1:0] qp;
    logic [1:0][BW-1:0] ei;
    logic [1:0][BW-1:0] eq;
  } vec_t;

  vec_t vecs[6];
  vec_t cur;
  bit   tone_mode = 1'b0;

  mul_fdc #(.BW(BW), .ABW(ABW)) dut (
    .clk_fs    (clk_fs),
    .rstb      (rstb),
    .Iin       (Iin),
    .Qin       (Qin),
    .Wif       (Wif),
    .Iout      (Iout),
    .Qout      (Qout),
    .out_valid (out_valid)
  );

  // ---------------- clock ----------------
  always #5 clk_fs = ~clk_fs;

  // Hard stop in case something stalls the sequence.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  function automatic vec_t mk(input string nm, input int wif,
                              input int i0, input int i1, input int i2, input int i3,
                              input int q0, input int q1, input int q2, input int q3,
                              input int ei0, input int ei1, input int eq0, input int eq1);
    vec_t v;
    v.name  = nm;
    v.wif   = ABW'(wif);
    v.ip[0] = BW'(i0); v.ip[1] = BW'(i1); v.ip[2] = BW'(i2); v.ip[3] = BW'(i3);
    v.qp[0] = BW'(q0); v.qp[1] = BW'(q1); v.qp[2] = BW'(q2); v.qp[3] = BW'(q3);
    v.ei[0] = BW'(ei0); v.ei[1] = BW'(ei1);
    v.eq[0] = BW'(eq0); v.eq[1] = BW'(eq1);
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_sample(input int n);
    if (tone_mode) begin
      Iin = BW'(rnd(1000.0 * $cos(2.0 * PI * real'(n) / 16.0)));
      Qin = BW'(rnd(1000.0 * $sin(2.0 * PI * real'(n) / 16.0)));
    end else begin
      Iin = cur.ip[2'(n)];
      Qin = cur.qp[2'(n)];
    end
  endtask

  task automatic hold_reset();
    rstb = 1'b0;
    repeat (2) @(negedge clk_fs);
  endtask

  task automatic release_reset();
    @(negedge clk_fs);
    Wif = cur.wif;
    drive_sample(0);
    rstb = 1'b1;
  endtask

  // Run n_cyc rising edges; compare each out_valid window against the scoreboard
  // (or the tone ranges) and feed the next sample on each falling edge.
  task automatic run_cycles(input int n_cyc, output int n_valid, output int first_cyc);
    logic [2*BW-1:0] e;
    n_valid   = 0;
    first_cyc = -1;
    for (int c = 1; c <= n_cyc; c++) begin
      @(posedge clk_fs);
      @(negedge clk_fs);
      if (out_valid === 1'b1) begin
        n_valid++;
        if (first_cyc < 0) first_cyc = c;
        if (tone_mode) begin
          check_range($sformatf("tone Iout w%0d", n_valid), int'(Iout), 998, 1000);
          check_range($sformatf("tone Qout w%0d", n_valid), int'(Qout), -2, 2);
        end else if (exp_q.size() == 0) begin
          check($sformatf("%s unexpected out_valid at edge", cur.name), c, -1);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s Iout w%0d", cur.name, n_valid), int'(Iout), int'($signed(e[2*BW-1:BW])));
          check($sformatf("%s Qout w%0d", cur.name, n_valid), int'(Qout), int'($signed(e[BW-1:0])));
        end
      end
      drive_sample(c);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nv, fc;

    // Gain of the mixer at phase 0 is 2047/2048 with floor rounding.
    vecs[0] = mk("dc_i",   0,  1000, 1000, 1000, 1000,  0, 0, 0, 0,  999, 999, 0, 0);
    vecs[1] = mk("dc_q",   0,  0, 0, 0, 0,  1000, 1000, 1000, 1000,  0, 0, 999, 999);
    // fs/4 tone cancels in the boxcar; floor(-999.5) = -1000 leaves a residue of -1.
    vecs[2] = mk("fs4_null", 0, 1000, 0, -1000, 0,  0, 0, 0, 0,  -1, -1, 0, 0);
    // 45-degree NCO steps with full-scale input: saturation in both directions.
    vecs[3] = mk("sat_45", 128, 2047, 2047, 2047, 2047,  2047, 2047, 2047, 2047,
                 1534, -1536, -513, 511);
    vecs[4] = mk("neg_fs", 0, -2048, -2048, -2048, -2048,  -2048, -2048, -2048, -2048,
                 -2047, -2047, -2047, -2047);
    // 90-degree NCO steps on a DC input: rotating products average to the floor bias.
    vecs[5] = mk("rot_90", 256, 1000, 1000, 1000, 1000,  0, 0, 0, 0,  -1, -1, -1, -1);

    // Reset state.
    #2;
    hold_reset();
    check("reset Iout", int'(Iout), 0);
    check("reset Qout", int'(Qout), 0);
    check("reset out_valid", int'(out_valid), 0);

    // Table-driven vectors: two output windows each.
    for (int k = 0; k < 6; k++) begin
      cur       = vecs[k];
      tone_mode = 1'b0;
      hold_reset();
      exp_q.delete();
      exp_q.push_back({cur.ei[0], cur.eq[0]});
      exp_q.push_back({cur.ei[1], cur.eq[1]});
      release_reset();
      run_cycles(13, nv, fc);
      check($sformatf("%s first out_valid edge", cur.name), fc, 8);
      check($sformatf("%s out_valid count", cur.name), nv, 2);
    end

    // Phase-matched tone at +fs/16 mixed down to DC.
    cur       = mk("tone", 64, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    tone_mode = 1'b1;
    hold_reset();
    exp_q.delete();
    release_reset();
    run_cycles(21, nv, fc);
    check("tone first out_valid edge", fc, 8);
    check("tone out_valid count", nv, 4);
    tone_mode = 1'b0;

    // Reset in the middle of window 2 (strobe cycle of window 1), then restart.
    cur = mk("rst_mid", 128, 2047, 2047, 2047, 2047,  2047, 2047, 2047, 2047,
             1534, -1536, -513, 511);
    hold_reset();
    exp_q.delete();
    exp_q.push_back({cur.ei[0], cur.eq[0]});
    release_reset();
    run_cycles(8, nv, fc);
    check("rst_mid window 1 seen", nv, 1);
    #2;
    rstb = 1'b0;
    #1;
    check("rst_mid async Iout", int'(Iout), 0);
    check("rst_mid async Qout", int'(Qout), 0);
    check("rst_mid async out_valid", int'(out_valid), 0);
    @(posedge clk_fs);
    exp_q.delete();
    exp_q.push_back({cur.ei[0], cur.eq[0]});
    exp_q.push_back({cur.ei[1], cur.eq[1]});
    release_reset();
    run_cycles(13, nv, fc);
    check("rst_mid restart first out_valid edge", fc, 8);
    check("rst_mid restart out_valid count", nv, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
